// File: rtl/tlp_fifo_writer_pkg.sv
// Shared constants, state encoding and FIFO word packing for the TLP FIFO writer.
package tlp_fifo_writer_pkg;

  localparam int unsigned FIFO_W   = 72;
  localparam int unsigned DATA_MSB = 63;
  localparam int unsigned START    = 64;
  localparam int unsigned LAST     = 65;
  localparam int unsigned EN_LO    = 66;
  localparam int unsigned EN_HI    = 67;
  localparam int unsigned IFG      = 68;

  localparam logic [2:0] FMT_MWR32 = 3'b010;
  localparam logic [2:0] FMT_MWR64 = 3'b011;
  localparam logic [4:0] TYPE_MWR  = 5'b00000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FWD,
    ST_FLUSH,
    ST_DROP
  } state_t;

  function automatic logic [FIFO_W-1:0] fifo_word(
    input logic [63:0] data,
    input logic [7:0]  keep,
    input logic        start,
    input logic        last
  );
    logic [FIFO_W-1:0] w;
    w             = '0;
    w[DATA_MSB:0] = data;
    w[START]      = start;
    w[LAST]       = last;
    w[EN_LO]      = (keep[3:0] == 4'hF);
    w[EN_HI]      = (keep[7:4] == 4'hF);
    w[IFG]        = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/tlp_fifo_writer_if.sv
// AXI-stream RX TLP bus from the PCIe core into the FIFO writer.
interface tlp_fifo_writer_if;
  logic [63:0] m_axis_rx_tdata;
  logic [7:0]  m_axis_rx_tkeep;
  logic        m_axis_rx_tlast;
  logic        m_axis_rx_tvalid;
  logic        m_axis_rx_tready;

  modport master (
    output m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tvalid,
    input  m_axis_rx_tready
  );

  modport slave (
    input  m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tvalid,
    output m_axis_rx_tready
  );
endinterface

// File: rtl/tlp_fifo_writer_hdr_match.sv
// Combinational MWr32/MWr64 header decode and remote-window address compare.
module tlp_hdr_match
  import tlp_fifo_writer_pkg::*;
#(
  parameter int unsigned WIN_BITS = 20
) (
  input  logic [7:0]  i_fmt_type,
  input  logic [63:0] i_beat1,
  input  logic        i_win_enable,
  input  logic [31:0] i_win_base,
  output logic        o_hit
);

  localparam logic [31:0] WIN_MASK = ~((32'd1 << WIN_BITS) - 32'd1);

  logic [2:0]  w_fmt;
  logic [4:0]  w_type;
  logic        w_mwr32;
  logic        w_mwr64;
  logic [31:0] w_addr;

  assign w_fmt   = i_fmt_type[7:5];
  assign w_type  = i_fmt_type[4:0];
  assign w_mwr32 = (w_fmt == FMT_MWR32) && (w_type == TYPE_MWR);
  // 64-bit form only qualifies when the upper address DW is zero
  assign w_mwr64 = (w_fmt == FMT_MWR64) && (w_type == TYPE_MWR) && (i_beat1[31:0] == '0);
  assign w_addr  = w_mwr64 ? i_beat1[63:32] : i_beat1[31:0];
  assign o_hit   = i_win_enable && (((w_addr ^ i_win_base) & WIN_MASK) == '0)
                   && (w_mwr32 || w_mwr64);

endmodule

// File: rtl/tlp_fifo_writer.sv
// Filters PCIe RX TLPs down to in-window memory writes and packs them into 72-bit FIFO words.
module tlp_fifo_writer
  import tlp_fifo_writer_pkg::*;
#(
  parameter int unsigned WIN_BITS = 20
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  tlp_fifo_writer_if.slave    rx,
  input  logic                win_enable,
  input  logic [31:0]         win_base,
  output logic [FIFO_W-1:0]   din,
  output logic                wr_en,
  input  logic                prog_full,
  output logic [31:0]         fwd_count,
  output logic [31:0]         drop_count
);

  state_t              r_state;
  state_t              w_next;
  logic [63:0]         r_hold_data;
  logic [7:0]          r_hold_keep;
  logic                r_tready;
  logic                r_wr_en;
  logic [FIFO_W-1:0]   r_din;
  logic [31:0]         r_fwd_count;
  logic [31:0]         r_drop_count;
  logic                w_accept;
  logic                w_hit;

  assign w_accept = rx.m_axis_rx_tvalid && r_tready;

  tlp_hdr_match #(.WIN_BITS(WIN_BITS)) u_hdr_match (
    .i_fmt_type   (r_hold_data[31:24]),
    .i_beat1      (rx.m_axis_rx_tdata),
    .i_win_enable (win_enable),
    .i_win_base   (win_base),
    .o_hit        (w_hit)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = rx.m_axis_rx_tlast ? ST_IDLE : ST_HDR;
      ST_HDR:   if (w_accept) begin
                  if (w_hit) w_next = rx.m_axis_rx_tlast ? ST_FLUSH : ST_FWD;
                  else       w_next = rx.m_axis_rx_tlast ? ST_IDLE  : ST_DROP;
                end
      ST_FWD:   if (w_accept && rx.m_axis_rx_tlast) w_next = ST_FLUSH;
      ST_FLUSH: w_next = ST_IDLE;
      ST_DROP:  if (w_accept && rx.m_axis_rx_tlast) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Ready is derived from the next state so it is already low during FLUSH
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= ST_IDLE;
      r_hold_data  <= '0;
      r_hold_keep  <= '0;
      r_tready     <= 1'b0;
      r_wr_en      <= 1'b0;
      r_din        <= '0;
      r_fwd_count  <= '0;
      r_drop_count <= '0;
    end else begin
      r_state  <= w_next;
      r_wr_en  <= 1'b0;
      r_tready <= ~prog_full && (w_next != ST_FLUSH);
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_hold_data <= rx.m_axis_rx_tdata;
          r_hold_keep <= rx.m_axis_rx_tkeep;
          if (rx.m_axis_rx_tlast) r_drop_count <= r_drop_count + 32'd1;
        end
        ST_HDR: if (w_accept) begin
          if (w_hit) begin
            r_din       <= fifo_word(r_hold_data, r_hold_keep, 1'b1, 1'b0);
            r_wr_en     <= 1'b1;
            r_hold_data <= rx.m_axis_rx_tdata;
            r_hold_keep <= rx.m_axis_rx_tkeep;
          end else begin
            r_drop_count <= r_drop_count + 32'd1;
          end
        end
        ST_FWD: if (w_accept) begin
          r_din       <= fifo_word(r_hold_data, r_hold_keep, 1'b0, 1'b0);
          r_wr_en     <= 1'b1;
          r_hold_data <= rx.m_axis_rx_tdata;
          r_hold_keep <= rx.m_axis_rx_tkeep;
        end
        ST_FLUSH: begin
          r_din       <= fifo_word(r_hold_data, r_hold_keep, 1'b0, 1'b1);
          r_wr_en     <= 1'b1;
          r_fwd_count <= r_fwd_count + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign rx.m_axis_rx_tready = r_tready;
  assign din                 = r_din;
  assign wr_en               = r_wr_en;
  assign fwd_count           = r_fwd_count;
  assign drop_count          = r_drop_count;

endmodule

// File: tb/tb_tlp_fifo_writer.sv
// Directed self-checking bench for tlp_fifo_writer.
module tb_tlp_fifo_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        win_enable;
  logic [31:0] win_base;
  logic [71:0] din;
  logic        wr_en;
  logic        prog_full;
  logic [31:0] fwd_count;
  logic [31:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;
  int n_stall = 0;

  logic [71:0] q[$];
  logic [63:0] pd[8];
  logic [7:0]  pk[8];

  always #5 clk = ~clk;

  tlp_fifo_writer_if rx ();

  tlp_fifo_writer #(.WIN_BITS(20)) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .rx         (rx),
    .win_enable (win_enable),
    .win_base   (win_base),
    .din        (din),
    .wr_en      (wr_en),
    .prog_full  (prog_full),
    .fwd_count  (fwd_count),
    .drop_count (drop_count)
  );

  always @(negedge clk) if (wr_en === 1'b1) q.push_back(din);

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int w;
    w = 0;
    rx.m_axis_rx_tdata  = d;
    rx.m_axis_rx_tkeep  = k;
    rx.m_axis_rx_tlast  = l;
    rx.m_axis_rx_tvalid = 1'b1;
    while (rx.m_axis_rx_tready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_stall += w;
    if (w >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL tready_wait: tready=%b after %0d cycles, required 1", rx.m_axis_rx_tready, w);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic send_pkt(input int n);
    for (int i = 0; i < n; i++) send_beat(pd[i], pk[i], (i == n - 1));
    rx.m_axis_rx_tvalid = 1'b0;
    rx.m_axis_rx_tlast  = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic load_mwr32();
    pd[0] = {32'h0000_000F, 32'h4000_0001}; pk[0] = 8'hFF;
    pd[1] = {32'hDEAD_BEEF, 32'h9000_0040}; pk[1] = 8'h0F;
  endtask

  task automatic load_mwr64();
    pd[0] = {32'h0000_00FF, 32'h6000_0008}; pk[0] = 8'hFF;
    pd[1] = {32'h9001_0000, 32'h0000_0000}; pk[1] = 8'hFF;
    pd[2] = 64'h0202_0202_0101_0101;         pk[2] = 8'hFF;
    pd[3] = 64'h0404_0404_0303_0303;         pk[3] = 8'hFF;
    pd[4] = 64'h0606_0606_0505_0505;         pk[4] = 8'hFF;
    pd[5] = 64'h0808_0808_0707_0707;         pk[5] = 8'hFF;
  endtask

  task automatic test_reset();
    rst = 1'b1; prog_full = 1'b0; win_enable = 1'b1; win_base = 32'h9000_0000;
    rx.m_axis_rx_tdata = '0; rx.m_axis_rx_tkeep = '0;
    rx.m_axis_rx_tlast = 1'b0; rx.m_axis_rx_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en: got %b required 0", wr_en); end
    n_cmp++; if (din !== 72'h0) begin n_err++; $display("FAIL rst_din: got %h required 0", din); end
    n_cmp++; if (rx.m_axis_rx_tready !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b required 0", rx.m_axis_rx_tready); end
    n_cmp++; if (fwd_count !== 32'd0) begin n_err++; $display("FAIL rst_fwd: got %0d required 0", fwd_count); end
    n_cmp++; if (drop_count !== 32'd0) begin n_err++; $display("FAIL rst_drop: got %0d required 0", drop_count); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (rx.m_axis_rx_tready !== 1'b1) begin n_err++; $display("FAIL idle_tready: got %b required 1", rx.m_axis_rx_tready); end
  endtask

  task automatic test_mwr32();
    logic [71:0] e[2];
    e[0] = 72'h0D_0000000F_40000001;
    e[1] = 72'h06_DEADBEEF_90000040;
    q.delete();
    load_mwr32();
    send_pkt(2);
    drain();
    n_cmp++; if (q.size() != 2) begin n_err++; $display("FAIL mwr32_count: got %0d writes required 2", q.size()); end
    for (int i = 0; i < 2 && i < q.size(); i++) begin
      n_cmp++; if (q[i] !== e[i]) begin n_err++; $display("FAIL mwr32_word%0d: got %h required %h", i, q[i], e[i]); end
    end
    n_cmp++; if (fwd_count !== 32'd1) begin n_err++; $display("FAIL mwr32_fwd: got %0d required 1", fwd_count); end
    q.delete();
  endtask

  task automatic test_mwr64();
    logic [71:0] e[6];
    e[0] = 72'h0D_000000FF_60000008;
    e[1] = 72'h0C_90010000_00000000;
    e[2] = 72'h0C_02020202_01010101;
    e[3] = 72'h0C_04040404_03030303;
    e[4] = 72'h0C_06060606_05050505;
    e[5] = 72'h0E_08080808_07070707;
    load_mwr64();
    send_pkt(6);
    drain();
    n_cmp++; if (q.size() != 6) begin n_err++; $display("FAIL mwr64_count: got %0d writes required 6", q.size()); end
    for (int i = 0; i < 6 && i < q.size(); i++) begin
      n_cmp++; if (q[i] !== e[i]) begin n_err++; $display("FAIL mwr64_word%0d: got %h required %h", i, q[i], e[i]); end
    end
    n_cmp++; if (fwd_count !== 32'd2) begin n_err++; $display("FAIL mwr64_fwd: got %0d required 2", fwd_count); end
    q.delete();
  endtask

  task automatic test_drop();
    int stall0;
    stall0 = n_stall;
    pd[0] = {32'h0000_00FF, 32'h0000_0001}; pk[0] = 8'hFF;
    pd[1] = {32'h0000_0000, 32'h9000_0100}; pk[1] = 8'h0F;
    pd[2] = {32'h0000_0000, 32'h4000_0001}; pk[2] = 8'hFF;
    pd[3] = {32'h1234_5678, 32'h8000_0000}; pk[3] = 8'hFF;
    send_beat(pd[0], pk[0], 1'b0);
    send_beat(pd[1], pk[1], 1'b1);
    send_beat(pd[2], pk[2], 1'b0);
    send_beat(pd[3], pk[3], 1'b1);
    rx.m_axis_rx_tvalid = 1'b0; rx.m_axis_rx_tlast = 1'b0;
    drain();
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL drop_writes: got %0d writes required 0", q.size()); end
    n_cmp++; if (drop_count !== 32'd2) begin n_err++; $display("FAIL drop_count: got %0d required 2", drop_count); end
    n_cmp++; if (n_stall != stall0) begin n_err++; $display("FAIL drop_tready: got %0d stall cycles required 0", n_stall - stall0); end
    q.delete();
  endtask

  task automatic test_stall();
    logic [71:0] e[6];
    e[0] = 72'h0D_000000FF_60000008;
    e[1] = 72'h0C_90010000_00000000;
    e[2] = 72'h0C_02020202_01010101;
    e[3] = 72'h0C_04040404_03030303;
    e[4] = 72'h0C_06060606_05050505;
    e[5] = 72'h0E_08080808_07070707;
    load_mwr64();
    for (int i = 0; i < 3; i++) send_beat(pd[i], pk[i], 1'b0);
    fork
      begin
        for (int j = 3; j < 6; j++) send_beat(pd[j], pk[j], (j == 5));
        rx.m_axis_rx_tvalid = 1'b0; rx.m_axis_rx_tlast = 1'b0;
      end
      begin
        prog_full = 1'b1;
        @(negedge clk);
        n_cmp++; if (rx.m_axis_rx_tready !== 1'b0) begin n_err++; $display("FAIL stall_tready: got %b required 0", rx.m_axis_rx_tready); end
        repeat (4) @(negedge clk);
        prog_full = 1'b0;
      end
    join
    drain();
    n_cmp++; if (q.size() != 6) begin n_err++; $display("FAIL stall_count: got %0d writes required 6", q.size()); end
    for (int i = 0; i < 6 && i < q.size(); i++) begin
      n_cmp++; if (q[i] !== e[i]) begin n_err++; $display("FAIL stall_word%0d: got %h required %h", i, q[i], e[i]); end
    end
    n_cmp++; if (fwd_count !== 32'd3) begin n_err++; $display("FAIL stall_fwd: got %0d required 3", fwd_count); end
    q.delete();
  endtask

  task automatic test_mid_reset();
    logic [71:0] e[2];
    e[0] = 72'h0D_0000000F_40000001;
    e[1] = 72'h06_DEADBEEF_90000040;
    pd[0] = {32'h0000_0000, 32'h4000_0004}; pk[0] = 8'hFF;
    pd[1] = {32'hAAAA_AAAA, 32'h9000_0000}; pk[1] = 8'hFF;
    pd[2] = 64'hBBBB_BBBB_CCCC_CCCC;         pk[2] = 8'hFF;
    for (int i = 0; i < 3; i++) send_beat(pd[i], pk[i], 1'b0);
    rst = 1'b1;
    rx.m_axis_rx_tvalid = 1'b0;
    @(negedge clk);
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL midrst_wr_en: got %b required 0", wr_en); end
    n_cmp++; if (fwd_count !== 32'd0) begin n_err++; $display("FAIL midrst_fwd: got %0d required 0", fwd_count); end
    n_cmp++; if (drop_count !== 32'd0) begin n_err++; $display("FAIL midrst_drop: got %0d required 0", drop_count); end
    rst = 1'b0;
    drain();
    q.delete();
    load_mwr32();
    send_pkt(2);
    drain();
    n_cmp++; if (q.size() != 2) begin n_err++; $display("FAIL postrst_count: got %0d writes required 2", q.size()); end
    for (int i = 0; i < 2 && i < q.size(); i++) begin
      n_cmp++; if (q[i] !== e[i]) begin n_err++; $display("FAIL postrst_word%0d: got %h required %h", i, q[i], e[i]); end
    end
    n_cmp++; if (fwd_count !== 32'd1) begin n_err++; $display("FAIL postrst_fwd: got %0d required 1", fwd_count); end
    n_cmp++; if (drop_count !== 32'd0) begin n_err++; $display("FAIL postrst_drop: got %0d required 0", drop_count); end
    q.delete();
  endtask

  task automatic test_win_disable();
    win_enable = 1'b0;
    load_mwr32();
    send_pkt(2);
    drain();
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL windis_writes: got %0d writes required 0", q.size()); end
    n_cmp++; if (drop_count !== 32'd1) begin n_err++; $display("FAIL windis_drop: got %0d required 1", drop_count); end
    n_cmp++; if (fwd_count !== 32'd1) begin n_err++; $display("FAIL windis_fwd: got %0d required 1", fwd_count); end
    win_enable = 1'b1;
    q.delete();
  endtask

  initial begin
    test_reset();
    test_mwr32();
    test_mwr64();
    test_drop();
    test_stall();
    test_mid_reset();
    test_win_disable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
